// File: rtl/nibble_add_sched_pkg.sv
// Shared types and constants for the nibble-serial add scheduler.
package nibble_add_sched_pkg;

  localparam int SLICE_W         = 4;
  localparam int NIBBLES_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/nibble_add_sched_nibble_adder.sv
// Combinational 4-bit ripple-carry slice shared by every nibble of every add.
module nibble_adder
  import nibble_add_sched_pkg::*;
(
  input  logic [SLICE_W-1:0] a_i,
  input  logic [SLICE_W-1:0] b_i,
  input  logic               cin_i,
  output logic [SLICE_W-1:0] sum_o,
  output logic               cout_o
);

  logic [SLICE_W:0] carry;

  always_comb begin
    carry[0] = cin_i;
    for (int i = 0; i < SLICE_W; i++) begin
      sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
      carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end
    cout_o = carry[SLICE_W];
  end

endmodule

// File: rtl/nibble_add_sched.sv
// Two-requester adder: round-robin grant, then one nibble per clock through a single slice.
module nibble_add_sched
  import nibble_add_sched_pkg::*;
#(
  parameter int NIBBLES = NIBBLES_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req0_valid,
  output logic                       req0_ready,
  input  logic [SLICE_W*NIBBLES-1:0] req0_a,
  input  logic [SLICE_W*NIBBLES-1:0] req0_b,
  input  logic                       req0_cin,
  input  logic                       req1_valid,
  output logic                       req1_ready,
  input  logic [SLICE_W*NIBBLES-1:0] req1_a,
  input  logic [SLICE_W*NIBBLES-1:0] req1_b,
  input  logic                       req1_cin,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic                       rsp_id,
  output logic [SLICE_W*NIBBLES-1:0] rsp_sum,
  output logic                       rsp_cout,
  output logic                       busy
);

  localparam int W     = SLICE_W * NIBBLES;
  localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBBLES - 1);

  state_e           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             id_q, id_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic               gnt_id;
  logic [SLICE_W-1:0] slice_a, slice_b, slice_sum;
  logic               slice_cout;

  assign slice_a = a_q[cnt_q*SLICE_W +: SLICE_W];
  assign slice_b = b_q[cnt_q*SLICE_W +: SLICE_W];

  nibble_adder u_slice (
    .a_i    (slice_a),
    .b_i    (slice_b),
    .cin_i  (carry_q),
    .sum_o  (slice_sum),
    .cout_o (slice_cout)
  );

  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    state_d    = state_q;
    ptr_d      = ptr_q;
    a_d        = a_q;
    b_d        = b_q;
    sum_d      = sum_q;
    carry_d    = carry_q;
    cout_d     = cout_q;
    id_d       = id_q;
    cnt_d      = cnt_q;
    gnt_id     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Ready is withheld while reset is asserted so no grant can be seen and then dropped.
        if (rst_n && (req0_valid || req1_valid)) begin
          gnt_id  = (req0_valid && req1_valid) ? ptr_q : req1_valid;
          ptr_d   = ~gnt_id;
          id_d    = gnt_id;
          cnt_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          state_d = ST_RUN;
          if (gnt_id) begin
            req1_ready = 1'b1;
            a_d        = req1_a;
            b_d        = req1_b;
            carry_d    = req1_cin;
          end else begin
            req0_ready = 1'b1;
            a_d        = req0_a;
            b_d        = req0_b;
            carry_d    = req0_cin;
          end
        end
      end
      ST_RUN: begin
        sum_d[cnt_q*SLICE_W +: SLICE_W] = slice_sum;
        carry_d = slice_cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_NIB) begin
          cout_d  = slice_cout;
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      id_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rsp_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_sum   = sum_q;
  assign rsp_cout  = cout_q;
  assign rsp_id    = id_q;

endmodule

// File: tb/tb_nibble_add_sched.sv
// Directed bench for nibble_add_sched with hand-computed expected results.
module tb_nibble_add_sched;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_cin;
  logic [15:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_cin;
  logic [15:0] req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_cout, busy;
  logic [15:0] rsp_sum;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  nibble_add_sched #(.NIBBLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cin   (req0_cin),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cin   (req1_cin),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one request, then follow it through to its handshake.
  task automatic do_add(input bit which, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic [15:0] exp_sum, input logic exp_cout,
                        input string tag);
    int lat;
    if (which) begin
      req1_a = a; req1_b = b; req1_cin = cin; req1_valid = 1'b1;
    end else begin
      req0_a = a; req0_b = b; req0_cin = cin; req0_valid = 1'b1;
    end
    #1;
    check({tag, "_ready"}, which ? req1_ready : req0_ready, 1);
    check({tag, "_other_ready"}, which ? req0_ready : req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, 4);
    check({tag, "_sum"}, rsp_sum, exp_sum);
    check({tag, "_cout"}, rsp_cout, exp_cout);
    check({tag, "_id"}, rsp_id, which);
    rsp_ready = 1'b1;
    tick();
    check({tag, "_valid_drop"}, rsp_valid, 0);
    check({tag, "_idle"}, busy, 0);
    rsp_ready = 1'b0;
  endtask

  initial begin
    int n, lat, gid, last_cyc;
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
    rsp_ready = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sum", rsp_sum, 16'h0000);
    check("rst_cout", rsp_cout, 0);
    check("rst_id", rsp_id, 0);
    check("rst_ready0", req0_ready, 0);
    check("rst_ready1", req1_ready, 0);
    rst_n = 1'b1;
    tick();

    // Basic adds and carry boundaries
    do_add(1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, "add_basic");
    do_add(1'b1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, "add_ripple");
    do_add(1'b0, 16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, "add_msb_cin");
    do_add(1'b1, 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, "add_cin_only");

    // Round-robin with both requesters valid continuously after reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req0_a = 16'h0011; req0_b = 16'h0022; req0_cin = 1'b0;
    req1_a = 16'h0F00; req1_b = 16'h0100; req1_cin = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    rsp_ready  = 1'b1;
    #1;
    last_cyc = 0;
    for (int g = 0; g < 4; g++) begin
      n = 0;
      while (!(req0_ready || req1_ready) && n < 20) begin
        tick();
        n++;
      end
      check("rr_grant_seen", req0_ready | req1_ready, 1);
      check("rr_exclusive", req0_ready & req1_ready, 0);
      gid = req1_ready ? 1 : 0;
      check("rr_order", gid, g % 2);
      if (g > 0) check("rr_spacing", cyc - last_cyc, 6);
      last_cyc = cyc;
      tick();
      lat = 0;
      while (!rsp_valid && lat < 20) begin
        tick();
        lat++;
      end
      check("rr_latency", lat, 4);
      check("rr_id", rsp_id, gid);
      check("rr_sum", rsp_sum, (gid == 1) ? 16'h1001 : 16'h0033);
      if (g == 3) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      tick();
    end
    rsp_ready = 1'b0;
    check("rr_end_idle", busy, 0);

    // Response held while the consumer stalls for three cycles
    req0_a = 16'h0ABC; req0_b = 16'h0123; req0_cin = 1'b0; req0_valid = 1'b1;
    #1;
    check("hold_grant", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("hold_latency", lat, 4);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("hold_ready0", req0_ready, 0);
      check("hold_ready1", req1_ready, 0);
      tick();
      check("hold_valid", rsp_valid, 1);
      check("hold_sum", rsp_sum, 16'h0BDF);
      check("hold_cout", rsp_cout, 0);
      check("hold_id", rsp_id, 0);
    end
    rsp_ready = 1'b1;
    #1;
    check("hs_no_accept0", req0_ready, 0);
    check("hs_no_accept1", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b0;
    check("hs_valid_drop", rsp_valid, 0);
    check("hs_idle", busy, 0);
    tick();

    // Reset during RUN after nibble 2; pointer must return to requester 0
    req0_a = 16'h1111; req0_b = 16'h2222; req0_cin = 1'b0; req0_valid = 1'b1;
    #1;
    check("abort_grant", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    tick();
    tick();
    tick();
    check("abort_running", busy, 1);
    rst_n = 1'b0;
    tick();
    check("abort_valid", rsp_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_sum", rsp_sum, 16'h0000);
    check("abort_cout", rsp_cout, 0);
    check("abort_id", rsp_id, 0);
    check("abort_ready0", req0_ready, 0);
    check("abort_ready1", req1_ready, 0);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rsp_valid) n++;
    end
    check("abort_no_rsp", n, 0);
    req0_a = 16'h0005; req0_b = 16'h0007; req0_cin = 1'b0;
    req1_a = 16'h0100; req1_b = 16'h0200; req1_cin = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    check("post_rst_grant0", req0_ready, 1);
    check("post_rst_grant1", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("post_rst_latency", lat, 4);
    check("post_rst_sum", rsp_sum, 16'h000C);
    check("post_rst_id", rsp_id, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("post_rst_done", rsp_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nibble_add_sched.md
NIBBLE_ADD_SCHED -- requirements
Module: nibble_add_sched

Interface
REQ-001 Parameter NIBBLES, default 4, number of 4-bit slices per operand; operand width W = 4*NIBBLES.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 req0_valid  input  1  requester 0 has an add pending.
REQ-005 req0_ready  output  1  requester 0 operands accepted this cycle.
REQ-006 req0_a, req0_b  input  W  requester 0 operands.
REQ-007 req0_cin  input  1  requester 0 carry-in.
REQ-008 req1_valid, req1_ready, req1_a, req1_b, req1_cin  same directions and widths as requester 0, for requester 1.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  consumer accepts result.
REQ-011 rsp_id  output  1  requester index owning the result.
REQ-012 rsp_sum  output  W  sum modulo 2^W.
REQ-013 rsp_cout  output  1  carry out of MSB.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 One shared 4-bit ripple-carry slice SHALL perform all additions, one nibble per clock, LSB nibble first.
REQ-016 FSM states SHALL be IDLE, RUN and DONE only.
REQ-017 IDLE: if any reqN_valid, grant exactly one requester, assert its reqN_ready combinationally in that same cycle, latch a, b, cin and id, clear the nibble counter, go to RUN.
REQ-018 Arbitration: single valid wins; both valid resolved by a round-robin pointer; pointer SHALL be set to the non-granted index on each grant.
REQ-019 reqN_ready SHALL be low in RUN and DONE; a valid deasserted before ready has no effect.
REQ-020 RUN: each cycle add nibble k of latched a and b plus the stored carry, write result nibble k, store the slice carry-out, increment k.
REQ-021 Carry into nibble 0 SHALL be the latched cin.
REQ-022 After nibble NIBBLES-1: go to DONE, rsp_cout = final carry; rsp_valid rises exactly NIBBLES cycles after the accepting edge.
REQ-023 DONE: rsp_valid=1; rsp_sum, rsp_cout and rsp_id held stable until rsp_ready=1; on handshake go to IDLE, rsp_valid low next cycle.
REQ-024 No request SHALL be accepted in the cycle of the DONE handshake; minimum spacing between grants is NIBBLES+2 cycles.
REQ-025 Overflow SHALL wrap; no saturation; rsp_cout is the only overflow indication.

Reset
REQ-026 rst_n low at a clock edge SHALL force IDLE, pointer=0 (requester 0 favoured), counter=0, carry=0, rsp_sum=0, rsp_cout=0, rsp_id=0, rsp_valid=0, busy=0, both reqN_ready=0.
REQ-027 Reset in RUN or DONE SHALL discard the operation silently; no rsp_valid is produced for it.

Structure
REQ-028 A shared package SHALL hold the FSM state enumeration, the slice width constant (4), and the default NIBBLES.
REQ-029 One sub-module, nibble_adder (combinational 4-bit ripple-carry: a, b, cin -> sum, cout), SHALL be instantiated exactly once.
REQ-030 Operand and result registers SHALL be W bits wide; the counter SHALL be ceil(log2(NIBBLES)) bits wide, with a minimum of 1.

Verification
REQ-031 req0 a=0x1234 b=0x4321 cin=0 -> rsp_sum=0x5555, cout=0, id=0, rsp_valid 4 cycles after accept.
REQ-032 req1 a=0xFFFF b=0x0001 cin=0 -> rsp_sum=0x0000, cout=1, id=1 (carry crosses every nibble).
REQ-033 a=0x8000 b=0x8000 cin=1 -> rsp_sum=0x0001, cout=1; a=0 b=0 cin=1 -> 0x0001, cout=0.
REQ-034 Both valid continuously after reset, rsp_ready=1 -> grant order 0,1,0,1; each rsp_id matches its grant.
REQ-035 rsp_ready held low 3 cycles in DONE -> rsp_* stable, both reqN_ready low, handshake on cycle 4.
REQ-036 rst_n low after nibble 2 in RUN -> next cycle all outputs 0, state IDLE, next simultaneous request grants requester 0.
